// File: rtl/or_sopc_pkg.sv
// ---------------------------------------------------------------------------
// or_sopc_pkg
// Shared definitions for the tiny accumulator SoC:
//   - instruction field widths (4-bit opcode, 8-bit immediate)
//   - opcode encodings as an enum
//   - the default 16-entry program image, packed with entry i at bits [i*12 +: 12]
// No ports (package).
// ---------------------------------------------------------------------------
package or_sopc_pkg;

  localparam int OPCODE_W  = 4;
  localparam int IMM_W     = 8;
  localparam int INSTR_W   = OPCODE_W + IMM_W;
  localparam int ROM_DEPTH = 16;
  localparam int PC_W      = 4;

  typedef enum logic [OPCODE_W-1:0] {
    OP_NOP  = 4'd0,
    OP_LDI  = 4'd1,
    OP_ADDI = 4'd2,
    OP_OUT  = 4'd3,
    OP_DIR  = 4'd4,
    OP_WAIT = 4'd5,
    OP_JMP  = 4'd6,
    OP_XORI = 4'd7,
    OP_IN   = 4'd8
  } opcode_e;

  // Default program: binary up-counter on the LEDs.
  //   0 DIR 0xFF; 1 LDI 0x00; 2 OUT; 3 WAIT 0; 4 ADDI 0x01; 5 JMP 2; 6-15 NOP
  // Written highest entry first so that entry 0 lands in the low bits.
  localparam logic [ROM_DEPTH*INSTR_W-1:0] DEFAULT_ROM = {
    {10{INSTR_W'(0)}},
    {OP_JMP,  8'h02},
    {OP_ADDI, 8'h01},
    {OP_WAIT, 8'h00},
    {OP_OUT,  8'h00},
    {OP_LDI,  8'h00},
    {OP_DIR,  8'hFF}
  };

endpackage

// File: rtl/or_sopc_seq.sv
// ---------------------------------------------------------------------------
// or_sopc_seq
// ROM-programmed 8-bit accumulator sequencer. Holds the program counter,
// accumulator, WAIT stall counter, the ROM image and the GPIO output/enable
// registers.
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-low reset
//   i_pinSync  in   [7:0] GPIO pin values after the top-level synchroniser
//   o_gpioOut  out  [7:0] registered GPIO output data
//   o_gpioOe   out  [7:0] registered GPIO output enables (1 = drive)
// ---------------------------------------------------------------------------
module or_sopc_seq
  import or_sopc_pkg::*;
#(
  parameter int                             DELAY_CYCLES = 16,
  parameter logic [ROM_DEPTH*INSTR_W-1:0]   ROM_INIT     = DEFAULT_ROM
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_pinSync,
  output logic [7:0] o_gpioOut,
  output logic [7:0] o_gpioOe
);

  // Wide enough to hold 256*DELAY_CYCLES, the longest possible stall.
  localparam int CNT_W = $clog2(256 * DELAY_CYCLES) + 1;

  logic [PC_W-1:0]    r_pc, w_pcNext;
  logic [7:0]         r_acc, w_accNext;
  logic [7:0]         r_gpioOut, w_gpioOutNext;
  logic [7:0]         r_gpioOe, w_gpioOeNext;
  logic [CNT_W-1:0]   r_waitCnt, w_waitCntNext;
  logic [CNT_W-1:0]   w_waitTotal;
  logic [INSTR_W-1:0] w_rom [ROM_DEPTH];
  logic [INSTR_W-1:0] w_instr;
  opcode_e            w_op;
  logic [IMM_W-1:0]   w_imm;

  // Unpack the flat ROM parameter into an addressable table.
  for (genvar g = 0; g < ROM_DEPTH; g++) begin : g_rom
    assign w_rom[g] = ROM_INIT[g*INSTR_W +: INSTR_W];
  end

  assign w_instr     = w_rom[r_pc];
  assign w_op        = opcode_e'(w_instr[INSTR_W-1 -: OPCODE_W]);
  assign w_imm       = w_instr[IMM_W-1:0];
  assign w_waitTotal = (CNT_W'(w_imm) + CNT_W'(1)) * CNT_W'(DELAY_CYCLES);

  // Instruction decode / execute. Every instruction advances pc by default;
  // WAIT holds pc and counts until the last cycle of its stall, on which it
  // advances like any other instruction and clears the counter.
  always_comb begin
    w_pcNext      = r_pc + PC_W'(1);
    w_accNext     = r_acc;
    w_gpioOutNext = r_gpioOut;
    w_gpioOeNext  = r_gpioOe;
    w_waitCntNext = '0;
    case (w_op)
      OP_LDI:  w_accNext     = w_imm;
      OP_ADDI: w_accNext     = r_acc + w_imm;
      OP_OUT:  w_gpioOutNext = r_acc;
      OP_DIR:  w_gpioOeNext  = w_imm;
      OP_WAIT: begin
        if (r_waitCnt != w_waitTotal - CNT_W'(1)) begin
          w_pcNext      = r_pc;
          w_waitCntNext = r_waitCnt + CNT_W'(1);
        end
      end
      OP_JMP:  w_pcNext      = w_imm[PC_W-1:0];
      OP_XORI: w_accNext     = r_acc ^ w_imm;
      OP_IN:   w_accNext     = i_pinSync;
      default: ;
    endcase
  end

  // Architectural state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc      <= '0;
      r_acc     <= '0;
      r_gpioOut <= '0;
      r_gpioOe  <= '0;
      r_waitCnt <= '0;
    end else begin
      r_pc      <= w_pcNext;
      r_acc     <= w_accNext;
      r_gpioOut <= w_gpioOutNext;
      r_gpioOe  <= w_gpioOeNext;
      r_waitCnt <= w_waitCntNext;
    end
  end

  assign o_gpioOut = r_gpioOut;
  assign o_gpioOe  = r_gpioOe;

endmodule

// File: rtl/or_sopc_top.sv
// ---------------------------------------------------------------------------
// or_sopc_top
// Minimal demo SoC: accumulator sequencer driving an 8-bit bidirectional
// GPIO port. The default program shows a binary up-counter on the LEDs.
// Ports:
//   clk  in     system clock, rising edge
//   rst  in     synchronous active-low reset
//   led  inout  [7:0] GPIO pins; bit i driven when its enable is set,
//               otherwise high-Z; always readable through a 2-flop sync
// ---------------------------------------------------------------------------
module or_sopc_top
  import or_sopc_pkg::*;
#(
  parameter int                           DELAY_CYCLES = 16,
  parameter logic [ROM_DEPTH*INSTR_W-1:0] ROM_INIT     = DEFAULT_ROM
) (
  input  logic       clk,
  input  logic       rst,
  inout  wire  [7:0] led
);

  logic [7:0] r_pinMeta;
  logic [7:0] r_pinSync;
  logic [7:0] w_gpioOut;
  logic [7:0] w_gpioOe;

  // Two-flop synchroniser for the asynchronous pin values; IN reads the
  // second stage.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pinMeta <= '0;
      r_pinSync <= '0;
    end else begin
      r_pinMeta <= led;
      r_pinSync <= r_pinMeta;
    end
  end

  or_sopc_seq #(
    .DELAY_CYCLES (DELAY_CYCLES),
    .ROM_INIT     (ROM_INIT)
  ) u_seq (
    .clk       (clk),
    .rst       (rst),
    .i_pinSync (r_pinSync),
    .o_gpioOut (w_gpioOut),
    .o_gpioOe  (w_gpioOe)
  );

  // Per-bit tri-state pad drivers.
  for (genvar g = 0; g < 8; g++) begin : g_pad
    assign led[g] = w_gpioOe[g] ? w_gpioOut[g] : 1'bz;
  end

endmodule

// File: tb/tb_or_sopc_top.sv
// ---------------------------------------------------------------------------
// tb_or_sopc_top
// Bench for or_sopc_top: default counter program (scoreboard driven), reset
// during WAIT, and two custom ROM images (output masking and pin input).
// ---------------------------------------------------------------------------
module tb_or_sopc_top;
  import or_sopc_pkg::*;

  localparam int D      = 16;
  localparam int PERIOD = D + 3;

  localparam logic [ROM_DEPTH*INSTR_W-1:0] ROM_C1 = {
    {10{12'h000}}, 12'h605, 12'h300, 12'h7FF, 12'h300, 12'h1A5, 12'h40F
  };
  localparam logic [ROM_DEPTH*INSTR_W-1:0] ROM_C2 = {
    {8{12'h000}}, 12'h607, 12'h300, 12'h4FF, 12'h800,
    12'h000, 12'h000, 12'h000, 12'h400
  };

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstMain, rstC1, rstC2;
  logic       drvEn;
  logic [7:0] drvVal;
  wire  [7:0] ledMain, ledC1, ledC2;

  assign ledC2 = drvEn ? drvVal : 8'hzz;

  or_sopc_top #(.DELAY_CYCLES(D)) dutMain (.clk(clk), .rst(rstMain), .led(ledMain));
  or_sopc_top #(.DELAY_CYCLES(D), .ROM_INIT(ROM_C1)) dutC1 (.clk(clk), .rst(rstC1), .led(ledC1));
  or_sopc_top #(.DELAY_CYCLES(D), .ROM_INIT(ROM_C2)) dutC2 (.clk(clk), .rst(rstC2), .led(ledC2));

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    int          edgeNo;
    logic [15:0] pins;
  } exp_t;
  exp_t sbq[$];

  // Pin view: {enables, driven values}; undriven bits show as 0 in the value half.
  function automatic logic [15:0] pinView(input logic [7:0] val, input logic [7:0] oe);
    return {oe, val & oe};
  endfunction

  // Edge numbering relative to reset release: edge 0 is the first rising
  // edge that samples rstMain high.
  int edgeIdx = -1;
  always @(posedge clk) begin
    if (rstMain) edgeIdx = edgeIdx + 1;
    else         edgeIdx = -1;
  end

  // Monitor: every change of the main instance's pins is popped against the
  // scoreboard, checking both value and the edge it appeared on.
  logic        monOn = 1'b0;
  logic [15:0] lastObs = 16'h0;
  always @(negedge clk) begin : monitor
    logic [15:0] obs;
    exp_t        e;
    if (monOn) begin
      obs = {dutMain.w_gpioOe, ledMain & dutMain.w_gpioOe};
      if (obs !== lastObs) begin
        lastObs = obs;
        vectors = vectors + 1;
        if (sbq.size() == 0) begin
          miscompares = miscompares + 1;
          $display("[TB] FAIL unexpectedChange edge=%0d got=%h required=none", edgeIdx, obs);
        end else begin
          e = sbq.pop_front();
          if (e.pins !== obs || e.edgeNo != edgeIdx)
            begin
              miscompares = miscompares + 1;
              $display("[TB] FAIL counterStep got=%h@edge%0d required=%h@edge%0d",
                       obs, edgeIdx, e.pins, e.edgeNo);
            end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors = vectors + 1;
    if (act !== exp) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL %s got=%h required=%h", name, act, exp);
    end
  endtask

  // Queue the expected counter sequence (edge 0 shows 0x00, value n appears
  // on edge 2+n*PERIOD, modulo 256) and release the main reset.
  task automatic applyStimulus(input int nValues);
    exp_t e;
    e.edgeNo = 0;
    e.pins   = pinView(8'h00, 8'hFF);
    sbq.push_back(e);
    for (int n = 1; n <= nValues; n++) begin
      e.edgeNo = 2 + n * PERIOD;
      e.pins   = pinView(8'(n % 256), 8'hFF);
      sbq.push_back(e);
    end
    @(negedge clk);
    rstMain = 1'b1;
  endtask

  task automatic waitDrain(input string name, input int budget);
    int c;
    c = 0;
    while (sbq.size() != 0 && c < budget) begin
      @(posedge clk);
      #1;
      c++;
    end
    if (sbq.size() != 0) begin
      vectors     = vectors + 1;
      miscompares = miscompares + 1;
      $display("[TB] FAIL %s timeout got=%0d pending required=0 pending", name, sbq.size());
      sbq.delete();
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("[TB] FAIL watchdog got=timeout required=finish");
    $fatal(1, "[TB] simulation hung");
  end

  initial begin : stim
    int resetEdge;
    int c;
    rstMain = 1'b0;
    rstC1   = 1'b0;
    rstC2   = 1'b0;
    drvEn   = 1'b1;
    drvVal  = 8'h3C;

    // Reset state
    repeat (10) @(posedge clk);
    #1;
    checkOutput("resetPins", {dutMain.w_gpioOe, ledMain & dutMain.w_gpioOe}, pinView(8'h00, 8'h00));
    checkOutput("resetAcc", {8'h00, dutMain.u_seq.r_acc}, 16'h0000);
    checkOutput("resetPc", {12'h000, dutMain.u_seq.r_pc}, 16'h0000);
    checkOutput("resetPinsC1", {dutC1.w_gpioOe, ledC1 & dutC1.w_gpioOe}, pinView(8'h00, 8'h00));

    // 300 counter steps including the 0xFF -> 0x00 wrap
    $display("[TB] running default program for 300 steps");
    lastObs = 16'h0;
    monOn   = 1'b1;
    applyStimulus(300);
    waitDrain("countRun", 300 * PERIOD + 50);

    // Restart, then reset somewhere inside the WAIT while 0x05 is shown
    monOn = 1'b0;
    @(negedge clk);
    rstMain = 1'b0;
    repeat ($urandom_range(1, 5)) @(posedge clk);
    #1;
    lastObs = 16'h0;
    monOn   = 1'b1;
    applyStimulus(5);
    waitDrain("toValue5", 5 * PERIOD + 50);
    resetEdge = 2 + 5 * PERIOD + 1 + $urandom_range(0, D - 1);
    c = 0;
    while (edgeIdx < resetEdge && c < 200) begin
      @(posedge clk);
      #1;
      c++;
    end
    checkOutput("beforeMidReset", {dutMain.w_gpioOe, ledMain & dutMain.w_gpioOe}, pinView(8'h05, 8'hFF));
    monOn = 1'b0;
    @(negedge clk);
    rstMain = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midWaitResetPins", {dutMain.w_gpioOe, ledMain & dutMain.w_gpioOe}, pinView(8'h00, 8'h00));
    checkOutput("midWaitResetCnt", 16'(dutMain.u_seq.r_waitCnt), 16'h0000);
    checkOutput("midWaitResetPc", {12'h000, dutMain.u_seq.r_pc}, 16'h0000);
    repeat ($urandom_range(1, 5)) @(posedge clk);
    #1;
    lastObs = 16'h0;
    monOn   = 1'b1;
    applyStimulus(3);
    waitDrain("restart", 3 * PERIOD + 50);
    monOn = 1'b0;

    // Custom ROM: partial direction mask, LDI/OUT/XORI
    @(negedge clk);
    rstC1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("c1Edge2", {dutC1.w_gpioOe, ledC1 & dutC1.w_gpioOe}, pinView(8'hA5, 8'h0F));
    repeat (2) @(posedge clk);
    #1;
    checkOutput("c1Edge4", {dutC1.w_gpioOe, ledC1 & dutC1.w_gpioOe}, pinView(8'hA5 ^ 8'hFF, 8'h0F));
    repeat (7) @(posedge clk);
    #1;
    checkOutput("c1Hold", {dutC1.w_gpioOe, ledC1 & dutC1.w_gpioOe}, pinView(8'hA5 ^ 8'hFF, 8'h0F));

    // Custom ROM: read externally driven pins, then drive them back out
    @(negedge clk);
    rstC2 = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    drvEn = 1'b0;
    checkOutput("c2InAcc", {8'h00, dutC2.u_seq.r_acc}, {8'h00, drvVal});
    checkOutput("c2Undriven", {8'h00, dutC2.w_gpioOe}, 16'h0000);
    @(posedge clk);
    #1;
    checkOutput("c2DirOn", {dutC2.w_gpioOe, ledC2 & dutC2.w_gpioOe}, pinView(8'h00, 8'hFF));
    @(posedge clk);
    #1;
    checkOutput("c2Out", {dutC2.w_gpioOe, ledC2 & dutC2.w_gpioOe}, pinView(8'h3C, 8'hFF));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
